uart_tx_fifo: RTL and testbench

Parametrised successor to the single-byte UART transmitter. It serialises words of configurable width through a small transmit FIFO and a programmable baud divider. Parity and stop-bit count are selectable per word. It sits between the bus-side producer (valid/ready handshake) and the serial TX_OUT pin, and allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO, per-word parity/stop options and
// a baud divider latched at the start of each frame.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a word
// START  | driving the start bit (low)
// DATA   | shifting data bits out, LSB first
// PARITY | driving the parity bit (only when the word asked for one)
// STOP   | driving one or two high stop bits, then chain or go idle
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             P_DATA,
    input  logic                              PAR_EN,
    input  logic                              PAR_TYP,
    input  logic                              STOP2,
    input  logic                              DATA_VALID,
    output logic                              DATA_READY,
    input  logic [DIV_WIDTH-1:0]              BAUD_DIV,
    output logic                              TX_OUT,
    output logic                              Busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_LEVEL
);

    localparam int ENTRY_W = DATA_WIDTH + 3;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO: entry = {STOP2, PAR_TYP, PAR_EN, P_DATA}
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign DATA_READY = (level != LVL_FULL);
    assign push       = DATA_VALID & DATA_READY;
    assign fifo_empty = (level == '0);
    assign head       = mem[rd_ptr];
    assign FIFO_LEVEL = level;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {STOP2, PAR_TYP, PAR_EN, P_DATA};
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t                state, state_n;
    logic [DIV_WIDTH-1:0]  baud_cnt, baud_n;
    logic [DIV_WIDTH-1:0]  div_q, div_n;
    logic [BIT_W-1:0]      bit_cnt, bit_n;
    logic                  stop_cnt, stop_n;
    logic [DATA_WIDTH-1:0] shreg, sh_n;
    logic                  par_en_q, pen_n;
    logic                  par_bit_q, pbit_n;
    logic                  stop2_q, s2_n;
    logic                  tx_q, tx_n;
    logic                  baud_tc;
    logic                  start_frame;

    logic [DATA_WIDTH-1:0] e_data;
    logic                  e_pen;
    logic                  e_ptyp;
    logic                  e_stop2;

    assign e_data  = head[DATA_WIDTH-1:0];
    assign e_pen   = head[DATA_WIDTH];
    assign e_ptyp  = head[DATA_WIDTH+1];
    assign e_stop2 = head[DATA_WIDTH+2];
    assign baud_tc = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            div_q     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            div_q     <= div_n;
            bit_cnt   <= bit_n;
            stop_cnt  <= stop_n;
            shreg     <= sh_n;
            par_en_q  <= pen_n;
            par_bit_q <= pbit_n;
            stop2_q   <= s2_n;
            tx_q      <= tx_n;
        end
    end

    always_comb begin
        state_n     = state;
        baud_n      = baud_cnt;
        div_n       = div_q;
        bit_n       = bit_cnt;
        stop_n      = stop_cnt;
        sh_n        = shreg;
        pen_n       = par_en_q;
        pbit_n      = par_bit_q;
        s2_n        = stop2_q;
        tx_n        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        // Every bit is div_q+1 clocks: count down, reload at terminal count.
        if (state != IDLE) begin
            baud_n = baud_tc ? div_q : (baud_cnt - 1'b1);
        end

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (baud_tc) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                    sh_n    = shreg >> 1;
                    bit_n   = BIT_LAST;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    if (bit_cnt != '0) begin
                        tx_n  = shreg[0];
                        sh_n  = shreg >> 1;
                        bit_n = bit_cnt - 1'b1;
                    end else if (par_en_q) begin
                        state_n = PARITY;
                        tx_n    = par_bit_q;
                    end else begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                        stop_n  = stop2_q;
                    end
                end
            end
            PARITY: begin
                if (baud_tc) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    stop_n  = stop2_q;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    if (stop_cnt) begin
                        stop_n = 1'b0;
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Frame launch: the divider is captured here so that a mid-frame
        // BAUD_DIV change only affects the next frame.
        if (start_frame) begin
            pop     = 1'b1;
            state_n = START;
            tx_n    = 1'b0;
            sh_n    = e_data;
            pen_n   = e_pen;
            pbit_n  = (^e_data) ^ e_ptyp;
            s2_n    = e_stop2;
            div_n   = BAUD_DIV;
            baud_n  = BAUD_DIV;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = (state != IDLE) | (level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: fixed frame vectors, burst/reset/baud-change
// sequences, and random traffic checked against a frame-level queue model.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   P_DATA;
    logic            PAR_EN;
    logic            PAR_TYP;
    logic            STOP2;
    logic            DATA_VALID;
    logic            DATA_READY;
    logic [DIVW-1:0] BAUD_DIV;
    logic            TX_OUT;
    logic            Busy;
    logic [2:0]      FIFO_LEVEL;

    uart_tx_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .DIV_WIDTH (DIVW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .P_DATA    (P_DATA),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .BAUD_DIV  (BAUD_DIV),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy),
        .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of pending words, and the current frame
    // expanded into one expected line level per clock.
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          pt;
        logic          s2;
    } word_t;

    word_t mq[$];
    logic  line_q[$];
    bit    model_on = 1'b0;

    task automatic build_frame(input word_t w, input int div);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w.d[i]);
        if (w.pe) bits.push_back((^w.d) ^ w.pt);
        bits.push_back(1'b1);
        if (w.s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int j = 0; j <= div; j++) line_q.push_back(bits[i]);
        end
    endtask

    task automatic model_step();
        word_t w;
        bit    push_m;
        if (reset) begin
            mq.delete();
            line_q.delete();
        end else begin
            push_m = DATA_VALID && (mq.size() != DEPTH);
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && mq.size() > 0) begin
                w = mq.pop_front();
                build_frame(w, int'(BAUD_DIV));
            end
            if (push_m) begin
                w.d  = P_DATA;
                w.pe = PAR_EN;
                w.pt = PAR_TYP;
                w.s2 = STOP2;
                mq.push_back(w);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("mon_tx",    32'(TX_OUT),     32'((line_q.size() > 0) ? line_q[0] : 1'b1));
            check("mon_busy",  32'(Busy),       32'((line_q.size() > 0) || (mq.size() > 0)));
            check("mon_ready", 32'(DATA_READY), 32'(mq.size() != DEPTH));
            check("mon_level", 32'(FIFO_LEVEL), 32'(mq.size()));
        end
    end

    task automatic wait_idle(input int budget);
        int k = 0;
        while (Busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (Busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: Busy still %b after %0d cycles", Busy, budget);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame vectors: expected line bit i is pat[i], each held div+1 clocks
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0]   d;
        logic            pe;
        logic            pt;
        logic            s2;
        logic [DIVW-1:0] div;
        int              len;
        logic [11:0]     pat;
    } vec_t;

    vec_t vecs[6];
    logic samp [0:1023];
    int   n, k, idx, ok, zeros, lowseen;
    int   acc_k[6];
    bit   acc, saw_full;

    initial begin
        vecs[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, s2: 1'b0, div: 16'd0, len: 11, pat: 12'b010101001010};
        vecs[1] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, s2: 1'b1, div: 16'd3, len: 48, pat: 12'b111000000000};
        vecs[2] = '{d: 8'hFF, pe: 1'b0, pt: 1'b0, s2: 1'b0, div: 16'd1, len: 20, pat: 12'b001111111110};
        vecs[3] = '{d: 8'h3C, pe: 1'b1, pt: 1'b1, s2: 1'b0, div: 16'd2, len: 33, pat: 12'b011001111000};
        vecs[4] = '{d: 8'h81, pe: 1'b1, pt: 1'b0, s2: 1'b1, div: 16'd0, len: 12, pat: 12'b110100000010};
        vecs[5] = '{d: 8'h01, pe: 1'b1, pt: 1'b0, s2: 1'b0, div: 16'd0, len: 11, pat: 12'b011000000010};

        reset      = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        BAUD_DIV   = '0;
        repeat (2) @(negedge clk);
        check("rst_tx",    32'(TX_OUT),     32'd1);
        check("rst_busy",  32'(Busy),       32'd0);
        check("rst_ready", 32'(DATA_READY), 32'd1);
        check("rst_level", 32'(FIFO_LEVEL), 32'd0);
        model_on = 1'b1;
        reset    = 1'b0;
        @(negedge clk);

        // Single-frame vectors
        for (int r = 0; r < 6; r++) begin
            wait_idle(200);
            P_DATA     = vecs[r].d;
            PAR_EN     = vecs[r].pe;
            PAR_TYP    = vecs[r].pt;
            STOP2      = vecs[r].s2;
            BAUD_DIV   = vecs[r].div;
            DATA_VALID = 1'b1;
            @(negedge clk);
            DATA_VALID = 1'b0;
            check("lat_busy",  32'(Busy),       32'd1);
            check("lat_tx",    32'(TX_OUT),     32'd1);
            check("lat_level", 32'(FIFO_LEVEL), 32'd1);
            n = 0;
            @(negedge clk);
            while (Busy === 1'b1 && n < 1000) begin
                samp[n] = TX_OUT;
                n++;
                @(negedge clk);
            end
            check("frame_len", 32'(n), 32'(vecs[r].len));
            ok = (n == vecs[r].len) ? 1 : 0;
            if (ok == 1) begin
                for (int i = 0; i < n; i++) begin
                    if (samp[i] !== vecs[r].pat[i / (int'(vecs[r].div) + 1)]) ok = 0;
                end
            end
            check("frame_bits", 32'(ok), 32'd1);
            check("frame_end_tx", 32'(TX_OUT), 32'd1);
        end

        // Burst of six words into a four-deep FIFO, full-FIFO push blocking
        wait_idle(200);
        BAUD_DIV   = 16'd15;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        idx        = 0;
        k          = 0;
        saw_full   = 1'b0;
        P_DATA     = 8'hA0;
        DATA_VALID = 1'b1;
        while (idx < 6 && k < 3000) begin
            if (idx == 5 && DATA_READY === 1'b1) begin
                check("pop_frees_level", 32'(FIFO_LEVEL), 32'(DEPTH - 1));
            end
            acc = (DATA_READY === 1'b1);
            @(posedge clk);
            if (acc) begin
                acc_k[idx] = k;
                idx++;
            end
            @(negedge clk);
            k++;
            if (idx == 5 && !saw_full) begin
                check("full_level", 32'(FIFO_LEVEL), 32'(DEPTH));
                check("full_ready", 32'(DATA_READY), 32'd0);
                saw_full = 1'b1;
            end
            if (idx < 6) P_DATA = 8'hA0 + 8'(idx);
        end
        DATA_VALID = 1'b0;
        check("burst_accepts", 32'(idx), 32'd6);
        if (idx == 6) begin
            check("fill_consecutive", 32'(acc_k[4] - acc_k[0]), 32'd4);
            check("sixth_accept",     32'(acc_k[5] - acc_k[0]), 32'd162);
            while (Busy === 1'b1 && k < acc_k[0] + 3000) begin
                @(negedge clk);
                k++;
            end
            check("burst_busy_span", 32'(k - acc_k[0]), 32'd962);
        end

        // Reset in the middle of a frame with words still queued
        wait_idle(200);
        BAUD_DIV   = 16'd3;
        PAR_EN     = 1'b1;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            P_DATA = 8'h5A ^ 8'(i);
            @(negedge clk);
        end
        DATA_VALID = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst_level", 32'(FIFO_LEVEL), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_tx",    32'(TX_OUT),     32'd1);
        check("midrst_busy",  32'(Busy),       32'd0);
        check("midrst_level", 32'(FIFO_LEVEL), 32'd0);
        check("midrst_ready", 32'(DATA_READY), 32'd1);
        lowseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) lowseen++;
        end
        check("no_restart", 32'(lowseen), 32'd0);

        // Divider change mid-frame applies only to the next frame
        PAR_EN     = 1'b0;
        STOP2      = 1'b0;
        BAUD_DIV   = 16'd1;
        P_DATA     = 8'hFF;
        DATA_VALID = 1'b1;
        @(negedge clk);
        @(negedge clk);
        DATA_VALID = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 500) begin
            samp[n] = TX_OUT;
            if (n == 5) BAUD_DIV = 16'd4;
            n++;
            @(negedge clk);
        end
        check("div_total", 32'(n), 32'd70);
        zeros = 0;
        for (int i = 0; i < n; i++) if (samp[i] === 1'b0) zeros++;
        check("div_zeros", 32'(zeros), 32'd7);
        if (n == 70) begin
            check("div_f1_stop",   32'(samp[19]), 32'd1);
            check("div_f2_start",  32'(samp[20]), 32'd0);
            check("div_f2_hold",   32'(samp[24]), 32'd0);
            check("div_f2_data",   32'(samp[25]), 32'd1);
        end

        // Random traffic against the model
        wait_idle(200);
        for (int c = 0; c < 4000; c++) begin
            DATA_VALID = ($urandom_range(0, 7) == 0);
            P_DATA     = DW'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            STOP2      = 1'($urandom);
            if ($urandom_range(0, 63) == 0) BAUD_DIV = DIVW'($urandom_range(0, 3));
            reset      = ($urandom_range(0, 799) == 0);
            @(negedge clk);
        end
        reset      = 1'b0;
        DATA_VALID = 1'b0;
        wait_idle(3000);
        check("final_tx",    32'(TX_OUT),     32'd1);
        check("final_level", 32'(FIFO_LEVEL), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
